// File: rtl/mem_lower_pkg.sv
// Shared geometry helpers, FSM encoding and macro tie-off values for the
// banked 1R1W memory lowering.
package mem_lower_pkg;

    // ceil(log2(n)), never below 1 so the result can size a port
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

    function automatic int unsigned nbank(input int unsigned depth, input int unsigned bank_depth);
        return (depth + bank_depth - 1) / bank_depth;
    endfunction

    function automatic int unsigned ncol(input int unsigned width, input int unsigned bank_width);
        return (width + bank_width - 1) / bank_width;
    endfunction

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Macro tie-offs; test enables are active-low, so 1 means inactive
    localparam logic [2:0] MACRO_EMA   = 3'd3;
    localparam logic       MACRO_EMAS  = 1'b0;
    localparam logic       MACRO_RET1N = 1'b1;
    localparam logic       MACRO_TEN   = 1'b1;
    localparam logic       MACRO_SE    = 1'b0;

endpackage

// File: rtl/mem_1r1w_leaf.sv
// One rf2 two-port register-file macro: active-high controls are converted to
// the macro's active-low pins, with a behavioural array standing in for it.
module mem_1r1w_leaf
    import mem_lower_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask
);

    logic             cena;
    logic             cenb;
    logic [WIDTH-1:0] wenb;
    logic [2:0]       ema;
    logic             emas;
    logic             ret1n;
    logic             tena;
    logic             tenb;
    logic             se;
    logic             macro_live;
    logic             unused_margin;

    assign cena  = ~rd_en;
    assign cenb  = ~wr_en;
    assign wenb  = ~wr_mask;
    assign ema   = MACRO_EMA;
    assign emas  = MACRO_EMAS;
    assign ret1n = MACRO_RET1N;
    assign tena  = MACRO_TEN;
    assign tenb  = MACRO_TEN;
    assign se    = MACRO_SE;

    // Timing margin pins only tune the real macro; the model ignores them
    assign unused_margin = ^{ema, emas};
    assign macro_live    = ret1n && tena && tenb && !se;

    logic [WIDTH-1:0] mem_array [DEPTH];
    logic [WIDTH-1:0] qa_q;

    // Same-address read and write in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (!cena && macro_live) begin
            qa_q <= mem_array[rd_addr];
        end
        if (!cenb && macro_live) begin
            mem_array[wr_addr] <= (mem_array[wr_addr] & wenb) | (wr_data & ~wenb);
        end
    end

    assign rd_data = qa_q;

endmodule

// File: rtl/mem_1r1w_banked.sv
// Logical DEPTH x WIDTH 1R1W memory tiled onto NBANK x NCOL rf2 leaves, with
// lane write mask, read-during-write forwarding, zero-fill and optional output register.
module mem_1r1w_banked
    import mem_lower_pkg::*;
#(
    parameter int unsigned DEPTH          = 48,
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BANK_DEPTH     = 32,
    parameter int unsigned BANK_WIDTH     = 16,
    parameter int unsigned MASK_GRAN      = 8,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned ADDR_W        = clog2(DEPTH),
    localparam int unsigned NLANE         = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [NLANE-1:0]  W0_mask,
    output logic              init_done
);

    localparam int unsigned LA_W   = clog2(BANK_DEPTH);
    localparam int unsigned NBANK  = nbank(DEPTH, BANK_DEPTH);
    localparam int unsigned NCOL   = ncol(WIDTH, BANK_WIDTH);
    localparam int unsigned PAD_W  = NCOL * BANK_WIDTH;
    localparam int unsigned BANK_W = clog2(NBANK);

    state_e            state_q, state_d;
    logic [LA_W-1:0]   clr_addr_q, clr_addr_d;
    logic              init_done_q, init_done_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_zero_q, s1_zero_d;
    logic [BANK_W-1:0] s1_bank_q, s1_bank_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [WIDTH-1:0]  fwd_data_q, fwd_data_d;
    logic [NLANE-1:0]  fwd_mask_q, fwd_mask_d;

    logic              r_in_range_c, w_in_range_c;
    logic [BANK_W-1:0] r_bank_c, w_bank_c;
    logic [LA_W-1:0]   r_local_c, w_local_c;
    logic              ready_c, clearing_c, rd_issue_c, wr_issue_c;

    assign r_in_range_c = 32'(R0_addr) < DEPTH;
    assign w_in_range_c = 32'(W0_addr) < DEPTH;
    assign r_bank_c     = BANK_W'(R0_addr >> LA_W);
    assign w_bank_c     = BANK_W'(W0_addr >> LA_W);
    assign r_local_c    = LA_W'(R0_addr);
    assign w_local_c    = LA_W'(W0_addr);

    assign ready_c    = (state_q == ST_READY);
    assign clearing_c = (state_q == ST_CLEAR);
    assign rd_issue_c = R0_en && ready_c;
    assign wr_issue_c = W0_en && ready_c && w_in_range_c;

    // Lane mask widened to per-bit enables; top-column padding is never written
    logic [PAD_W-1:0] w_bits_c;
    logic [PAD_W-1:0] w_data_pad_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask_bit
        assign w_bits_c[i] = W0_mask[i / MASK_GRAN];
    end
    if (PAD_W > WIDTH) begin : g_mask_pad
        assign w_bits_c[PAD_W-1:WIDTH] = '0;
    end
    assign w_data_pad_c = PAD_W'(W0_data);

    // During CLEAR every bank row writes zero at clr_addr with the full mask
    logic [LA_W-1:0]  leaf_wr_addr_c;
    logic [PAD_W-1:0] leaf_wr_data_c;
    logic [PAD_W-1:0] leaf_wr_mask_c;

    assign leaf_wr_addr_c = clearing_c ? clr_addr_q : w_local_c;
    assign leaf_wr_data_c = clearing_c ? '0 : w_data_pad_c;
    assign leaf_wr_mask_c = clearing_c ? '1 : w_bits_c;

    logic [PAD_W-1:0] bank_rd_c [NBANK];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic rd_en_c;
        logic wr_en_c;

        assign rd_en_c = rd_issue_c && r_in_range_c && (r_bank_c == BANK_W'(b));
        assign wr_en_c = clearing_c || (wr_issue_c && (w_bank_c == BANK_W'(b)));

        for (genvar c = 0; c < NCOL; c++) begin : g_col
            mem_1r1w_leaf #(
                .DEPTH (BANK_DEPTH),
                .WIDTH (BANK_WIDTH)
            ) u_leaf (
                .clk     (clock),
                .rd_en   (rd_en_c),
                .rd_addr (r_local_c),
                .rd_data (bank_rd_c[b][c*BANK_WIDTH +: BANK_WIDTH]),
                .wr_en   (wr_en_c),
                .wr_addr (leaf_wr_addr_c),
                .wr_data (leaf_wr_data_c[c*BANK_WIDTH +: BANK_WIDTH]),
                .wr_mask (leaf_wr_mask_c[c*BANK_WIDTH +: BANK_WIDTH])
            );
        end
    end

    // FSM next state and read-side capture; read context only moves on an issued read
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        s1_valid_d  = rd_issue_c;
        s1_zero_d   = s1_zero_q;
        s1_bank_d   = s1_bank_q;
        fwd_hit_d   = fwd_hit_q;
        fwd_data_d  = fwd_data_q;
        fwd_mask_d  = fwd_mask_q;

        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + LA_W'(1);
                if (clr_addr_q == LA_W'(BANK_DEPTH - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase

        init_done_d = (state_d == ST_READY);

        if (rd_issue_c) begin
            s1_zero_d  = !r_in_range_c;
            s1_bank_d  = r_bank_c;
            fwd_hit_d  = wr_issue_c && (R0_addr == W0_addr);
            fwd_data_d = W0_data;
            fwd_mask_d = W0_mask;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b1;
            s1_bank_q   <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
            fwd_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
            s1_valid_q  <= s1_valid_d;
            s1_zero_q   <= s1_zero_d;
            s1_bank_q   <= s1_bank_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
            fwd_mask_q  <= fwd_mask_d;
        end
    end

    assign init_done = init_done_q;

    // Merge forwarded lanes over the macro word; s1_zero covers out-of-range and post-reset
    logic [WIDTH-1:0] row_c;
    logic [WIDTH-1:0] merged_c;
    logic [WIDTH-1:0] result_c;

    assign row_c = bank_rd_c[s1_bank_q][WIDTH-1:0];

    for (genvar l = 0; l < NLANE; l++) begin : g_merge
        assign merged_c[l*MASK_GRAN +: MASK_GRAN] = (fwd_hit_q && fwd_mask_q[l])
            ? fwd_data_q[l*MASK_GRAN +: MASK_GRAN]
            : row_c[l*MASK_GRAN +: MASK_GRAN];
    end

    assign result_c = s1_zero_q ? '0 : merged_c;

    if (OUT_REG != 0) begin : g_out_reg
        logic             out_valid_q, out_valid_d;
        logic [WIDTH-1:0] out_data_q, out_data_d;

        always_comb begin
            out_valid_d = s1_valid_q;
            out_data_d  = s1_valid_q ? result_c : out_data_q;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign R0_valid = out_valid_q;
        assign R0_data  = out_data_q;
    end else begin : g_out_direct
        assign R0_valid = s1_valid_q;
        assign R0_data  = result_c;
    end

endmodule

// File: tb/tb_mem_1r1w_banked.sv
// Scoreboard bench: two instances (OUT_REG 0/1) checked against an array model,
// plus a CLEAR_ON_RESET=0 instance whose init_done timing is checked.
module tb_mem_1r1w_banked;

    localparam int unsigned DEPTH      = 48;
    localparam int unsigned BANK_DEPTH = 32;
    localparam int unsigned NLANE      = 8;
    localparam int unsigned GRAN       = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  r0_addr;
    logic        r0_en;
    logic [5:0]  w0_addr;
    logic        w0_en;
    logic [63:0] w0_data;
    logic [7:0]  w0_mask;

    logic [63:0] r_data  [3];
    logic        r_valid [3];
    logic        done    [3];

    always #5 clock = ~clock;

    mem_1r1w_banked #(.OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clock(clock), .reset(reset),
        .R0_addr(r0_addr), .R0_en(r0_en), .R0_data(r_data[0]), .R0_valid(r_valid[0]),
        .W0_addr(w0_addr), .W0_en(w0_en), .W0_data(w0_data), .W0_mask(w0_mask),
        .init_done(done[0])
    );

    mem_1r1w_banked #(.OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .R0_addr(r0_addr), .R0_en(r0_en), .R0_data(r_data[1]), .R0_valid(r_valid[1]),
        .W0_addr(w0_addr), .W0_en(w0_en), .W0_data(w0_data), .W0_mask(w0_mask),
        .init_done(done[1])
    );

    mem_1r1w_banked #(.OUT_REG(0), .CLEAR_ON_RESET(0)) u_noclr (
        .clock(clock), .reset(reset),
        .R0_addr(r0_addr), .R0_en(r0_en), .R0_data(r_data[2]), .R0_valid(r_valid[2]),
        .W0_addr(w0_addr), .W0_en(w0_en), .W0_data(w0_data), .W0_mask(w0_mask),
        .init_done(done[2])
    );

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] last_data [2];
    int          cyc = 0;
    int          since_rst = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [63:0] model_read(input int ra, input bit we, input int wa,
                                               input logic [63:0] wd, input logic [7:0] wm);
        logic [63:0] r;
        if (ra >= int'(DEPTH)) return 64'd0;
        r = ref_mem[ra];
        if (we && wa == ra) begin
            for (int l = 0; l < int'(NLANE); l++) begin
                if (wm[l]) r[l*GRAN +: GRAN] = wd[l*GRAN +: GRAN];
            end
        end
        return r;
    endfunction

    task automatic model_write(input int wa, input logic [63:0] wd, input logic [7:0] wm);
        for (int l = 0; l < int'(NLANE); l++) begin
            if (wm[l]) ref_mem[wa][l*GRAN +: GRAN] = wd[l*GRAN +: GRAN];
        end
    endtask

    task automatic check_init(input int idx, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL init_done dut%0d cyc=%0d got=%0b expected=%0b", idx, cyc, got, exp);
        end
    endtask

    task automatic check_port(input int idx, input logic v, input logic [63:0] d);
        exp_t e;
        int   qsize;
        qsize = (idx == 0) ? q0.size() : q1.size();
        checks++;
        if (v) begin
            if (qsize == 0) begin
                failures++;
                $display("FAIL rd_unexpected dut%0d cyc=%0d got=%h expected=no_read", idx, cyc, d);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                if (d !== e.data || cyc != e.due) begin
                    failures++;
                    $display("FAIL rd_data dut%0d got=%h@%0d expected=%h@%0d",
                             idx, d, cyc, e.data, e.due);
                end
                last_data[idx] = e.data;
            end
        end else begin
            if (qsize != 0) begin
                e = (idx == 0) ? q0[0] : q1[0];
                if (e.due <= cyc) begin
                    failures++;
                    $display("FAIL rd_missing dut%0d cyc=%0d got=valid0 expected=%h@%0d",
                             idx, cyc, e.data, e.due);
                    if (idx == 0) void'(q0.pop_front());
                    else          void'(q1.pop_front());
                end
            end
            if (d !== last_data[idx]) begin
                failures++;
                $display("FAIL rd_hold dut%0d cyc=%0d got=%h expected=%h", idx, cyc, d, last_data[idx]);
            end
        end
    endtask

    // Monitor: sample just after each rising edge
    always @(posedge clock) begin
        logic rst_s;
        rst_s = reset;
        cyc++;
        if (!rst_s) since_rst++;
        #1;
        check_init(0, done[0], !rst_s && since_rst >= int'(BANK_DEPTH));
        check_init(1, done[1], !rst_s && since_rst >= int'(BANK_DEPTH));
        check_init(2, done[2], !rst_s && since_rst >= 1);
        check_port(0, r_valid[0], r_data[0]);
        check_port(1, r_valid[1], r_data[1]);
    end

    task automatic step(input bit re, input int ra, input bit we, input int wa,
                        input logic [63:0] wd, input logic [7:0] wm);
        exp_t e;
        @(negedge clock);
        r0_en   = re;
        r0_addr = 6'(ra);
        w0_en   = we;
        w0_addr = 6'(wa);
        w0_data = wd;
        w0_mask = wm;
        if (!reset && since_rst >= int'(BANK_DEPTH)) begin
            if (re) begin
                e.data = model_read(ra, we, wa, wd, wm);
                e.due  = cyc + 1;
                q0.push_back(e);
                e.due  = cyc + 2;
                q1.push_back(e);
            end
            if (we && wa < int'(DEPTH)) model_write(wa, wd, wm);
        end
    endtask

    task automatic rand_step(input int addr_max);
        int          ra;
        int          wa;
        logic [63:0] wd;
        wa = $urandom_range(0, addr_max);
        ra = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, addr_max));
        wd = {$urandom, $urandom};
        step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, wd, 8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset(input int hold);
        @(negedge clock);
        reset = 1'b1;
        r0_en = 1'b0;
        w0_en = 1'b0;
        q0.delete();
        q1.delete();
        last_data[0] = 64'd0;
        last_data[1] = 64'd0;
        repeat (hold - 1) @(negedge clock);
        reset = 1'b0;
        since_rst = 0;
        for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = 64'd0;
    endtask

    initial begin
        reset   = 1'b1;
        r0_en   = 1'b0;
        r0_addr = '0;
        w0_en   = 1'b0;
        w0_addr = '0;
        w0_data = '0;
        w0_mask = '0;
        last_data[0] = 64'd0;
        last_data[1] = 64'd0;
        for (int a = 0; a < int'(DEPTH); a++) ref_mem[a] = 64'd0;

        do_reset(3);
        // Traffic during CLEAR must be ignored
        repeat (BANK_DEPTH) rand_step(55);
        step(0, 0, 0, 0, 64'd0, 8'h00);

        step(1, 0, 0, 0, 64'd0, 8'h00);
        step(1, 31, 0, 0, 64'd0, 8'h00);
        step(1, 32, 0, 0, 64'd0, 8'h00);
        step(1, 47, 0, 0, 64'd0, 8'h00);

        step(0, 0, 1, 40, 64'h0123456789ABCDEF, 8'hFF);
        step(1, 40, 0, 0, 64'd0, 8'h00);
        step(1, 8, 0, 0, 64'd0, 8'h00);

        step(0, 0, 1, 5, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        step(0, 0, 1, 5, 64'h0, 8'h0F);
        step(1, 5, 0, 0, 64'd0, 8'h00);

        step(0, 0, 1, 3, 64'h1111111111111111, 8'hFF);
        step(1, 3, 1, 3, 64'hAAAAAAAAAAAAAAAA, 8'hF0);
        step(1, 3, 0, 0, 64'd0, 8'h00);

        step(0, 0, 1, 50, 64'hDEADBEEFDEADBEEF, 8'hFF);
        step(1, 50, 0, 0, 64'd0, 8'h00);
        step(1, 18, 0, 0, 64'd0, 8'h00);
        repeat (3) step(0, 0, 0, 0, 64'd0, 8'h00);

        repeat (400) rand_step(55);

        // Reset with a read in flight, then again at clear cycle 10
        step(1, 40, 0, 0, 64'd0, 8'h00);
        do_reset(2);
        repeat (9) rand_step(55);
        do_reset(2);
        repeat (BANK_DEPTH) rand_step(55);

        repeat (150) rand_step(55);
        for (int a = 0; a < int'(DEPTH); a++) step(1, a, 0, 0, 64'd0, 8'h00);
        repeat (5) step(0, 0, 0, 0, 64'd0, 8'h00);

        checks++;
        if (q0.size() + q1.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", q0.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_1r1w_banked.md
# mem_1r1w_banked

Parametrised single-clock 1-read/1-write memory that tiles a logical DEPTH×WIDTH array onto NBANK×NCOL two-port register-file macro leaves. It adds several features the plain lowered memories lack: a per-lane write mask, read-during-write forwarding, an optional output register, out-of-range address protection, and a post-reset zero-fill sequencer. It sits between Chisel-generated `SyncReadMem` instances and the technology macros.

## Interface
- DEPTH, 48, logical words; ADDR_W = clog2(DEPTH)
- WIDTH, 64, logical word width in bits
- BANK_DEPTH, 32, words per macro; power of two; LA_W = clog2(BANK_DEPTH)
- BANK_WIDTH, 16, data bits used per macro
- MASK_GRAN, 8, bits per mask lane; divides BANK_WIDTH and WIDTH; NLANE = WIDTH/MASK_GRAN
- OUT_REG, 0, 1 adds one output pipeline stage
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset
- clock  in  1  sole clock; all ports synchronous to its rising edge
- reset  in  1  synchronous, active-high
- R0_addr  in  ADDR_W  read address
- R0_en  in  1  read request
- R0_data  out  WIDTH  read data
- R0_valid  out  1  R0_data carries the result of a read this cycle
- W0_addr  in  ADDR_W  write address
- W0_en  in  1  write request
- W0_data  in  WIDTH  write data
- W0_mask  in  NLANE  per-lane write enable; bit i covers bits [i*MASK_GRAN +: MASK_GRAN]
- init_done  out  1  high once the array is usable

## Operation
- Geometry:
  - NBANK = ceil(DEPTH/BANK_DEPTH); NCOL = ceil(WIDTH/BANK_WIDTH).
  - Bank index = addr >> LA_W; local address = addr[LA_W-1:0].
  - Top column is zero-padded and its padding bits are never compared or returned.
- Chip enable: only the addressed bank row is enabled, all NCOL macros in it. The macro write mask is derived per lane from W0_mask.
- Out-of-range (addr >= DEPTH): a write is dropped with no macro enabled. A read enables no macro and returns 0 with R0_valid asserted.
- FSM states are CLEAR and READY.
  - reset forces CLEAR, sets clr_addr = 0 and init_done = 0.
  - In CLEAR, every bank row writes 0 at clr_addr with the full mask. clr_addr increments each cycle. After clr_addr = BANK_DEPTH-1 the FSM moves to READY and init_done rises.
  - In CLEAR, W0_en and R0_en are ignored: writes are lost and no read is issued.
  - With CLEAR_ON_RESET = 0, reset goes directly to READY and init_done = 1 the cycle after reset deasserts.
- Read-during-write: if R0_en && W0_en && R0_addr == W0_addr (in range) in the same cycle, the result uses the new data for each lane where W0_mask = 1 and the old array data for other lanes. Capture W0_data, W0_mask and a hit flag in a forward register and merge them at the macro output.
- Hold: when no read is issued, R0_data holds its previous value and R0_valid = 0.
- Simultaneous write to one address and read of a different address: both proceed, no interaction.

## Timing
- Read latency is 1 + OUT_REG cycles from the R0_en edge to R0_data/R0_valid.
- Read row selection uses a registered bank index, as do the forward merge and the out-of-range flag. These delay through the same pipeline as the data.
- A write is visible to a non-colliding read issued the cycle after the write.
- Reset values: R0_data = 0, R0_valid = 0, init_done = 0 (1 one cycle after reset when CLEAR_ON_RESET = 0), FSM = CLEAR, clr_addr = 0, forward hit = 0, pipeline valids = 0.
- Reset asserted mid-CLEAR or mid-read: all in-flight reads are discarded (no R0_valid) and clearing restarts from 0.
- The CLEAR duration is exactly BANK_DEPTH cycles; init_done is high in cycle BANK_DEPTH after reset deasserts.

## Structure
- Package `mem_lower_pkg`: clog2 helper, geometry functions (nbank, ncol), the FSM state enum, and macro tie-off constants (EMA = 3, EMAS = 0, RET1N = 1, test/scan inputs inactive).
- Sub-module `mem_1r1w_leaf` wraps one rf2 macro: active-high enables converted to CEN, mask to write-enable bits, all tie-offs applied. It also provides a behavioural model for simulation.
- Top level: address decode, the FSM, the forward register, the output mux and the OUT_REG stage.

## Test plan
- Reset, then poll: init_done rises exactly 32 cycles after reset deasserts. Reads of addresses 0, 31, 32 and 47 return 0x0.
- Write addr 40 = 0x0123456789ABCDEF with mask 0xFF, then read 40 the next cycle: R0_data = 0x0123456789ABCDEF with R0_valid one cycle later. A read of addr 8 (same local address, other bank) returns 0.
- Write addr 5 = 0xFFFF...FF, then write addr 5 = 0 with mask 0x0F: a read returns 0xFFFFFFFF00000000.
- Same-cycle write addr 3 = 0xAAAA...AA with mask 0xF0 over old data 0x1111...11, plus read addr 3: returns 0xAAAAAAAA11111111.
- Write addr 50 (out of range), then read addr 50: returns 0 with R0_valid = 1. Addr 18 (alias local address) is unchanged.
- Assert reset at clear cycle 10: CLEAR restarts and init_done rises 32 cycles after the second reset deasserts. Repeat with OUT_REG = 1: all read latencies are 2.
